// File: rtl/rx_uart_param.sv
`default_nettype none
//==============================================================================
// Module   : rx_uart_param
// Desc     : Parameterised UART receiver (2-flop sync, optional parity, 1/2
//            stop bits) feeding a receive queue. Build option RX_UART_FIFO_EN
//            selects a FIFO_DEPTH circular buffer instead of one holding reg.
// Revision : 1.0
//==============================================================================
module rx_uart_param #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_rx,
    input  logic                 in_serial_rx,
    output logic [DATA_BITS-1:0] data_rx,
    output logic                 valid_rx,
    input  logic                 ready_rx,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 rx_busy
);

    localparam int unsigned c_cnt_w  = $clog2(CLKS_PER_BIT);
    localparam int unsigned c_idx_w  = $clog2(DATA_BITS + 1);
    localparam int unsigned c_word_w = DATA_BITS + 2;
    localparam logic [c_cnt_w-1:0] c_mid       = c_cnt_w'((CLKS_PER_BIT - 1) / 2);
    localparam logic [c_cnt_w-1:0] c_last      = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(DATA_BITS - 1);
    localparam logic               c_stop_last = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q;
    logic [c_cnt_w-1:0]   cnt_q;
    logic [c_idx_w-1:0]   idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 frame_q;
    logic                 par_q;
    logic                 busy_q;
    logic                 sync1_q, sync2_q, prev_q;

    // Synchroniser and edge history reset to idle-high so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge rst_rx) begin
        if (rst_rx) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= in_serial_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // cnt_q counts cycles since the synchronised falling edge, so the start sample lands at c_mid.
    always_ff @(posedge clk or posedge rst_rx) begin
        if (rst_rx) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            frame_q    <= 1'b0;
            par_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_q    <= S_START;
                        cnt_q      <= c_cnt_w'(1);
                        idx_q      <= '0;
                        stop_idx_q <= 1'b0;
                        frame_q    <= 1'b0;
                        par_q      <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == c_mid) begin
                        cnt_q <= '0;
                        if (sync2_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == c_last) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[DATA_BITS-1:1]};
                        if (idx_q == c_idx_last) begin
                            idx_q   <= '0;
                            state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt_q == c_last) begin
                        cnt_q   <= '0;
                        par_q   <= (PARITY != 0) && ((^{shift_q, sync2_q}) != (PARITY == 1));
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == c_last) begin
                        cnt_q <= '0;
                        if (!sync2_q) begin
                            frame_q <= 1'b1;
                        end
                        if (stop_idx_q == c_stop_last) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // The word is pushed on the final stop sample, folding that sample into the frame flag.
    logic                w_push;
    logic [c_word_w-1:0] w_word;
    assign w_push = (state_q == S_STOP) && (cnt_q == c_last) && (stop_idx_q == c_stop_last);
    assign w_word = {shift_q, frame_q | ~sync2_q, par_q};

    logic [c_word_w-1:0] w_head;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_do_push;
    logic                ovr_q, ovr_d;

    assign w_pop     = ready_rx & ~w_empty;
    assign w_do_push = w_push & (~w_full | w_pop);

`ifdef RX_UART_FIFO_EN
    localparam int unsigned c_aw = $clog2(FIFO_DEPTH);

    logic [c_word_w-1:0] mem_q [FIFO_DEPTH];
    logic [c_word_w-1:0] mem_d [FIFO_DEPTH];
    logic [c_aw:0]       wr_ptr_q, wr_ptr_d;
    logic [c_aw:0]       rd_ptr_q, rd_ptr_d;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                     (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
    assign w_head  = mem_q[rd_ptr_q[c_aw-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q[c_aw-1:0]] = w_word;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_rx) begin
        if (rst_rx) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
`else
    logic [c_word_w-1:0] hold_q, hold_d;
    logic                full_q, full_d;

    assign w_empty = ~full_q;
    assign w_full  = full_q;
    assign w_head  = hold_q;

    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        if (w_pop) begin
            full_d = 1'b0;
        end
        if (w_do_push) begin
            hold_d = w_word;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_rx) begin
        if (rst_rx) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
        end
    end
`endif

    assign ovr_d = ovr_q | (w_push & w_full & ~w_pop);

    always_ff @(posedge clk or posedge rst_rx) begin
        if (rst_rx) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign data_rx     = w_head[c_word_w-1:2];
    assign frame_err   = w_head[1];
    assign parity_err  = w_head[0];
    assign valid_rx    = ~w_empty;
    assign overrun_err = ovr_q;
    assign rx_busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_uart_param.sv
`default_nettype none
//==============================================================================
// Module   : tb_rx_uart_param
// Desc     : Directed self-checking bench for rx_uart_param (8N1 and 8E1
//            instances at 16 clocks per bit). Honours RX_UART_FIFO_EN.
// Revision : 1.0
//==============================================================================
module tb_rx_uart_param;

`ifdef RX_UART_FIFO_EN
    localparam int C_HELD = 4;
`else
    localparam int C_HELD = 1;
`endif

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       rx0  = 1'b1;
    logic       rx1  = 1'b1;
    logic       rdy0 = 1'b0;
    logic       rdy1 = 1'b0;
    logic [7:0] d0, d1;
    logic       v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, b0, b1;

    int n_vec = 0;
    int n_err = 0;
    int pops0 = 0;
    int base;

    logic [7:0] fr [5];
    logic [7:0] bits;

    rx_uart_param #(
        .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut (
        .clk(clk), .rst_rx(rst), .in_serial_rx(rx0), .data_rx(d0), .valid_rx(v0),
        .ready_rx(rdy0), .frame_err(fe0), .parity_err(pe0), .overrun_err(ov0), .rx_busy(b0)
    );

    rx_uart_param #(
        .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_par (
        .clk(clk), .rst_rx(rst), .in_serial_rx(rx1), .data_rx(d1), .valid_rx(v1),
        .ready_rx(rdy1), .frame_err(fe1), .parity_err(pe1), .overrun_err(ov1), .rx_busy(b1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (v0 && rdy0) begin
            pops0 <= pops0 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
        tick(16);
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input bit has_par,
                              input logic pbit, input logic stop);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (has_par) drive_bit(which, pbit);
        drive_bit(which, stop);
        drive_bit(which, 1'b1);
    endtask

    task automatic pop(input int which);
        if (which == 0) rdy0 = 1'b1;
        else            rdy1 = 1'b1;
        tick(1);
        rdy0 = 1'b0;
        rdy1 = 1'b0;
    endtask

    initial begin
        fr[0] = 8'h11; fr[1] = 8'h22; fr[2] = 8'h33; fr[3] = 8'h44; fr[4] = 8'h5A;

        // Reset state, checked while reset is asserted and before any clock edge
        #1;
        chk("rst_valid", v0, 0);
        chk("rst_busy", b0, 0);
        chk("rst_data", d0, 0);
        chk("rst_fe", fe0, 0);
        chk("rst_pe", pe0, 0);
        chk("rst_ovr", ov0, 0);
        chk("rst_par_valid", v1, 0);
        tick(3);
        rst = 1'b0;
        tick(4);

        // 0x55 8N1: valid rises exactly at the stop sample edge (10th edge into stop bit)
        bits = 8'h55;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(0, bits[i]);
        rx0 = 1'b1;
        tick(9);
        chk("x55_valid_early", v0, 0);
        tick(1);
        chk("x55_valid_rise", v0, 1);
        chk("x55_data", d0, 8'h55);
        chk("x55_fe", fe0, 0);
        chk("x55_pe", pe0, 0);
        tick(22);
        pop(0);
        chk("x55_popped", v0, 0);

        // ready with nothing queued must not disturb the queue
        rdy0 = 1'b1;
        tick(3);
        rdy0 = 1'b0;
        chk("empty_ready_ignored", v0, 0);

        // 5-clock glitch: busy during START, back in IDLE by clock 10, no push
        rx0 = 1'b0;
        tick(4);
        chk("glitch_busy", b0, 1);
        tick(1);
        rx0 = 1'b1;
        tick(5);
        chk("glitch_idle", b0, 0);
        tick(40);
        chk("glitch_nopush", v0, 0);

        // Even parity: 0x07 with parity 0 is wrong, 0x03 with parity 0 is right
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        chk("par07_valid", v1, 1);
        chk("par07_data", d1, 8'h07);
        chk("par07_pe", pe1, 1);
        chk("par07_fe", fe1, 0);
        pop(1);
        send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
        chk("par03_data", d1, 8'h03);
        chk("par03_pe", pe1, 0);
        pop(1);
        chk("par_empty", v1, 0);

        // Break: 20 bit times low yields one 0x00 word with frame error, no re-arm while low
        base = pops0;
        rx0 = 1'b0;
        tick(320);
        chk("brk_valid", v0, 1);
        chk("brk_data", d0, 8'h00);
        chk("brk_fe", fe0, 1);
        chk("brk_pe", pe0, 0);
        pop(0);
        tick(16);
        chk("brk_no_rearm", v0, 0);
        chk("brk_idle", b0, 0);
        rx0 = 1'b1;
        tick(32);
        send_frame(0, 8'hA3, 1'b0, 1'b0, 1'b1);
        chk("a3_data", d0, 8'hA3);
        chk("a3_fe", fe0, 0);
        pop(0);
        chk("a3_empty", v0, 0);
        chk("brk_push_count", pops0 - base, 2);
        chk("brk_no_ovr", ov0, 0);

        // Five frames into the queue with no consumer: overflow drops the tail
        for (int i = 0; i < 5; i++) send_frame(0, fr[i], 1'b0, 1'b0, 1'b1);
        chk("ovr_flag", ov0, 1);
        chk("ovr_valid", v0, 1);
        for (int i = 0; i < C_HELD; i++) begin
            chk($sformatf("ovr_word%0d", i), d0, fr[i]);
            pop(0);
            chk($sformatf("ovr_valid_after%0d", i), v0, (i < C_HELD - 1) ? 1 : 0);
        end
        chk("ovr_sticky", ov0, 1);

        // Reset during data bit 3 discards the partial word and clears overrun at once
        bits = 8'hA5;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, bits[i]);
        rx0 = bits[3];
        tick(5);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", b0, 0);
        chk("mid_rst_valid", v0, 0);
        chk("mid_rst_ovr", ov0, 0);
        rx0 = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(32);
        chk("post_rst_idle", b0, 0);
        chk("post_rst_nopush", v0, 0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        chk("x3c_valid", v0, 1);
        chk("x3c_data", d0, 8'h3C);
        chk("x3c_fe", fe0, 0);
        pop(0);
        chk("x3c_empty", v0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
